arm7tdmi_perf_sample_stream: RTL and testbench
==============================================

Name: arm7tdmi_perf_sample_stream

Overview:
Downstream consumer of the cache/MMU performance monitor's 32-bit event counters. It snapshots NUM_SRC counters, either periodically or on a manual trigger. For each enabled source it computes the delta since the previous snapshot and pushes a timestamped record into a FIFO, which the debug/trace port drains over a valid/ready handshake. It also provides a FIFO-level watermark interrupt and drop accounting.

Parameters:
NUM_SRC, 8, number of counter inputs sampled
FIFO_DEPTH, 16, record FIFO entries (power of 2)
TS_WIDTH, 16, sample-index timestamp width
PERIOD_WIDTH, 16, width of sample period register

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
enable  in  1  sampling enable
period  in  PERIOD_WIDTH  cycles between automatic samples; 0 = manual only
trigger  in  1  manual sample request pulse
src_mask  in  NUM_SRC  per-source record enable
counters_in  in  NUM_SRC*32  packed counter values, src i at [32i+31:32i]
counters_cleared  in  1  pulse: upstream counters were reset
rec_valid  out  1  FIFO head valid
rec_ready  in  1  consumer accepts head
rec_ts  out  TS_WIDTH  sample index of head record
rec_src  out  $clog2(NUM_SRC)  source id of head record
rec_delta  out  32  counter delta of head record
flush  in  1  empty FIFO, abort emission
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
watermark  in  $clog2(FIFO_DEPTH)+1  irq threshold; 0 disables
irq_watermark  out  1  level >= watermark (watermark != 0)
drop_count  out  16  records lost to full FIFO, saturating
missed_samples  out  8  requests lost while busy, saturating
busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0. FSM=IDLE; timer, ts, prev snapshots, FIFO pointers and counters all 0.
- Timer: counts only when enable=1 and period!=0. It generates tick when timer>=period-1, then returns to 0. A live period change takes effect immediately. When enable=0 the timer is held at 0.
- Request = (tick | trigger) & enable. Tick and trigger in the same cycle form one request.
- FSM IDLE: on request go to CAPTURE.
- FSM CAPTURE (1 cycle):
  - For each i: if cur<prev (unsigned), delta_i = cur; otherwise delta_i = cur-prev (32-bit).
  - prev<=cur; captured ts = ts; ts<=ts+1 (wraps modulo 2^TS_WIDTH).
  - Go to EMIT with idx=0.
- FSM EMIT: exactly NUM_SRC cycles, one idx per cycle.
  - If src_mask[idx] is set (mask sampled live), push {ts, idx, delta_idx}.
  - If the FIFO is full that cycle, do not push; drop_count++ (saturates at 16'hFFFF).
  - After idx=NUM_SRC-1, return to IDLE.
- Request while busy: lost; missed_samples++ (saturates at 8'hFF).
- counters_cleared in any state: all prev<=0 on the next edge. If it coincides with CAPTURE, the CAPTURE update of prev wins.
- Latency: request sampled at edge E0 -> CAPTURE during E0..E1 -> idx0 push at E2 -> rec_valid=1 after E2. A fully masked sample occupies NUM_SRC+1 cycles.
- FIFO is show-ahead; a pop occurs when rec_valid & rec_ready.
  - Push and pop in the same cycle with FIFO full: both happen, level unchanged, no drop.
  - Empty FIFO: no bypass; a pushed record becomes visible on the next cycle.
- flush: FIFO emptied and FSM forced to IDLE at the next edge, and that cycle's push is discarded. prev, ts, drop_count and missed_samples are retained.
- enable deasserted mid-EMIT: emission completes. The FIFO remains drainable while disabled.
- irq_watermark and busy are combinational from registered state.

Decomposition:
- arm7tdmi_pkg gets:
  - perf_rec_t (ts, src, delta)
  - perf_sample_state_t enum {PS_IDLE, PS_CAPTURE, PS_EMIT}
  - PERF_DROP_SAT and PERF_MISS_SAT constants
- One sub-module: arm7tdmi_perf_rec_fifo, a synchronous show-ahead FIFO of perf_rec_t with push/pop/flush/level.

Test Plan:
- period=0, counters src0=100/src1=5, mask=8'h03, trigger, rec_ready=1 -> records (ts0,src0,100), (ts0,src1,5); rec_valid first rises 2 edges after trigger.
- period=10, src0 incremented by 3 per window, mask=1 -> one record every 10 cycles, delta=3, ts 0,1,2…; missed_samples stays 0.
- prev src0=500, counters_cleared pulse, src0 becomes 7, trigger -> delta=7. Separately, without the clear, cur<prev -> delta=cur.
- rec_ready=0, mask=8'hFF, FIFO_DEPTH=16, three triggers spaced 20 cycles -> fifo_level=16, drop_count=8. watermark=12 -> irq_watermark=1 from level 12.
- trigger on two consecutive cycles, then again mid-EMIT -> one sample emitted, missed_samples=2.
- Flush during EMIT idx=3 with 5 records queued -> fifo_level=0 and busy=0 the next cycle. The next trigger's ts continues the sequence.

Source files
------------

// File: rtl/arm7tdmi_pkg.sv
// Shared types and constants for the ARM7TDMI cache/MMU performance sample stream.
// Record field widths must track the NUM_SRC / TS_WIDTH parameters of the sample stream top.
package arm7tdmi_pkg;

    localparam int unsigned PERF_TS_WIDTH  = 16;
    localparam int unsigned PERF_SRC_WIDTH = 3;

    localparam logic [15:0] PERF_DROP_SAT = 16'hFFFF;
    localparam logic [7:0]  PERF_MISS_SAT = 8'hFF;

    typedef struct packed {
        logic [PERF_TS_WIDTH-1:0]  ts;
        logic [PERF_SRC_WIDTH-1:0] src;
        logic [31:0]               delta;
    } perf_rec_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_CAPTURE,
        PS_EMIT
    } perf_sample_state_t;

    // A counter that went backwards was reset upstream, so its whole value is new activity.
    function automatic logic [31:0] perf_delta(input logic [31:0] cur, input logic [31:0] prev);
        return (cur < prev) ? cur : (cur - prev);
    endfunction

endpackage

// File: rtl/arm7tdmi_perf_rec_fifo.sv
// Synchronous show-ahead FIFO of performance records with flush and occupancy level.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module arm7tdmi_perf_rec_fifo
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  perf_rec_t                  din_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output perf_rec_t                  dout_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    perf_rec_t        mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        valid_o = (level_q != '0);
        full_o  = (level_q == (AW+1)'(DEPTH));
        do_pop  = pop_i && valid_o && !flush_i;
        do_push = push_i && !flush_i && (!full_o || do_pop);
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;

endmodule

// File: rtl/arm7tdmi_perf_sample_stream.sv
// Snapshots the performance counters periodically or on trigger and streams per-source
// deltas as timestamped records through a FIFO with watermark irq and loss accounting.
module arm7tdmi_perf_sample_stream
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned TS_WIDTH     = 16,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [PERIOD_WIDTH-1:0]       period,
    input  logic                          trigger,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic [NUM_SRC*32-1:0]         counters_in,
    input  logic                          counters_cleared,
    output logic                          rec_valid,
    input  logic                          rec_ready,
    output logic [TS_WIDTH-1:0]           rec_ts,
    output logic [$clog2(NUM_SRC)-1:0]    rec_src,
    output logic [31:0]                   rec_delta,
    input  logic                          flush,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic [$clog2(FIFO_DEPTH):0]   watermark,
    output logic                          irq_watermark,
    output logic [15:0]                   drop_count,
    output logic [7:0]                    missed_samples,
    output logic                          busy
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    perf_sample_state_t       state_q;
    logic [PERIOD_WIDTH-1:0]  timer_q, timer_d;
    logic [TS_WIDTH-1:0]      ts_q, cap_ts_q;
    logic [SRC_W-1:0]         idx_q;
    logic [31:0]              prev_q  [NUM_SRC];
    logic [31:0]              delta_q [NUM_SRC];
    logic [31:0]              cur     [NUM_SRC];
    logic [15:0]              drop_q, drop_d;
    logic [7:0]               miss_q, miss_d;

    logic       tick, request, push_req, pop, drop_ev, fifo_full;
    perf_rec_t  push_rec, head_rec;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            cur[i] = counters_in[32*i +: 32];
        end
    end

    // Timer restarts from 0 whenever sampling is off or period is manual-only.
    always_comb begin
        tick    = 1'b0;
        timer_d = timer_q;
        if (!enable || period == '0) begin
            timer_d = '0;
        end else if (timer_q >= period - PERIOD_WIDTH'(1)) begin
            tick    = 1'b1;
            timer_d = '0;
        end else begin
            timer_d = timer_q + PERIOD_WIDTH'(1);
        end
    end

    always_comb begin
        busy     = (state_q != PS_IDLE);
        request  = (tick || trigger) && enable;
        pop      = rec_valid && rec_ready;
        push_req = (state_q == PS_EMIT) && src_mask[idx_q] && !flush;
        drop_ev  = push_req && fifo_full && !pop;

        push_rec       = '0;
        push_rec.ts    = cap_ts_q;
        push_rec.src   = idx_q;
        push_rec.delta = delta_q[idx_q];

        drop_d = drop_q;
        if (drop_ev && drop_q != PERF_DROP_SAT) drop_d = drop_q + 16'd1;
        miss_d = miss_q;
        if (request && busy && miss_q != PERF_MISS_SAT) miss_d = miss_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            drop_q  <= '0;
            miss_q  <= '0;
        end else begin
            timer_q <= timer_d;
            drop_q  <= drop_d;
            miss_q  <= miss_d;
        end
    end

    // The clear is applied first so that a coincident CAPTURE overwrites prev afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= PS_IDLE;
            idx_q    <= '0;
            ts_q     <= '0;
            cap_ts_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                prev_q[i]  <= '0;
                delta_q[i] <= '0;
            end
        end else begin
            if (counters_cleared) begin
                for (int unsigned i = 0; i < NUM_SRC; i++) prev_q[i] <= '0;
            end
            if (flush) begin
                state_q <= PS_IDLE;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    PS_IDLE: begin
                        if (request) state_q <= PS_CAPTURE;
                    end
                    PS_CAPTURE: begin
                        for (int unsigned i = 0; i < NUM_SRC; i++) begin
                            delta_q[i] <= perf_delta(cur[i], prev_q[i]);
                            prev_q[i]  <= cur[i];
                        end
                        cap_ts_q <= ts_q;
                        ts_q     <= ts_q + TS_WIDTH'(1);
                        idx_q    <= '0;
                        state_q  <= PS_EMIT;
                    end
                    PS_EMIT: begin
                        if (idx_q == SRC_W'(NUM_SRC - 1)) begin
                            idx_q   <= '0;
                            state_q <= PS_IDLE;
                        end else begin
                            idx_q <= idx_q + SRC_W'(1);
                        end
                    end
                    default: state_q <= PS_IDLE;
                endcase
            end
        end
    end

    arm7tdmi_perf_rec_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .din_i   (push_rec),
        .pop_i   (pop),
        .flush_i (flush),
        .dout_o  (head_rec),
        .valid_o (rec_valid),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    // Head fields read as zero when empty so outputs are clean out of reset.
    assign rec_ts         = rec_valid ? head_rec.ts    : '0;
    assign rec_src        = rec_valid ? head_rec.src   : '0;
    assign rec_delta      = rec_valid ? head_rec.delta : '0;
    assign irq_watermark  = (watermark != '0) && (fifo_level >= watermark);
    assign drop_count     = drop_q;
    assign missed_samples = miss_q;

endmodule

// File: tb/tb_arm7tdmi_perf_sample_stream.sv
// Directed self-checking bench for arm7tdmi_perf_sample_stream.
module tb_arm7tdmi_perf_sample_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [15:0]  period;
    logic         trigger;
    logic [7:0]   src_mask;
    logic [255:0] counters_in;
    logic         counters_cleared;
    logic         rec_valid;
    logic         rec_ready;
    logic [15:0]  rec_ts;
    logic [2:0]   rec_src;
    logic [31:0]  rec_delta;
    logic         flush;
    logic [4:0]   fifo_level;
    logic [4:0]   watermark;
    logic         irq_watermark;
    logic [15:0]  drop_count;
    logic [7:0]   missed_samples;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    always #5 clk = ~clk;

    arm7tdmi_perf_sample_stream #(
        .NUM_SRC(8), .FIFO_DEPTH(16), .TS_WIDTH(16), .PERIOD_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .trigger(trigger),
        .src_mask(src_mask), .counters_in(counters_in), .counters_cleared(counters_cleared),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_ts(rec_ts), .rec_src(rec_src),
        .rec_delta(rec_delta), .flush(flush), .fifo_level(fifo_level), .watermark(watermark),
        .irq_watermark(irq_watermark), .drop_count(drop_count),
        .missed_samples(missed_samples), .busy(busy)
    );

    always @(negedge clk) if (rec_valid && rec_ready) pops++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; period = '0; trigger = 1'b0; src_mask = '0;
        counters_in = '0; counters_cleared = 1'b0; rec_ready = 1'b0; flush = 1'b0;
        watermark = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin step(); n++; end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rec_valid && n < 30) begin step(); n++; end
        check("valid_reached", {31'd0, rec_valid}, 32'd1);
    endtask

    task automatic sample_one(input string tag, input logic [15:0] ets, input logic [31:0] edelta);
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_valid();
        check({tag, "_ts"}, 32'(rec_ts), 32'(ets));
        check({tag, "_delta"}, rec_delta, edelta);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        int p0;

        // 1: reset state and a two-source manual sample with latency
        do_reset();
        check("rst_valid", {31'd0, rec_valid}, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_miss", 32'(missed_samples), 32'd0);
        check("rst_irq", {31'd0, irq_watermark}, 32'd0);
        check("rst_delta", rec_delta, 32'd0);
        src_mask = 8'h03; rec_ready = 1'b1;
        counters_in[31:0] = 32'd100; counters_in[63:32] = 32'd5;
        trigger = 1'b1; step(); trigger = 1'b0;
        check("lat_e0_valid", {31'd0, rec_valid}, 32'd0);
        check("lat_e0_busy", {31'd0, busy}, 32'd1);
        step();
        check("lat_e1_valid", {31'd0, rec_valid}, 32'd0);
        step();
        check("lat_e2_valid", {31'd0, rec_valid}, 32'd1);
        check("r0_ts", 32'(rec_ts), 32'd0);
        check("r0_src", 32'(rec_src), 32'd0);
        check("r0_delta", rec_delta, 32'd100);
        step();
        check("r1_valid", {31'd0, rec_valid}, 32'd1);
        check("r1_src", 32'(rec_src), 32'd1);
        check("r1_delta", rec_delta, 32'd5);
        step();
        check("r2_empty", {31'd0, rec_valid}, 32'd0);
        wait_idle();

        // 2: periodic sampling, period 10, src0 grows by 3 per window
        do_reset();
        src_mask = 8'h01; rec_ready = 1'b1; period = 16'd10; counters_in[31:0] = 32'd3;
        n = 0;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (s == 12 || s == 22 || s == 32) counters_in[31:0] = counters_in[31:0] + 32'd3;
            if (rec_valid) begin
                check("per_ts", 32'(rec_ts), 32'(n));
                check("per_delta", rec_delta, 32'd3);
                n++;
            end
        end
        check("per_count", 32'(n), 32'd3);
        check("per_miss", 32'(missed_samples), 32'd0);
        enable = 1'b0;
        wait_idle();

        // 3: counters_cleared vs counter wrap
        do_reset();
        src_mask = 8'h01; rec_ready = 1'b1;
        counters_in[31:0] = 32'd500;
        sample_one("clr_a", 16'd0, 32'd500);
        counters_cleared = 1'b1; step(); counters_cleared = 1'b0;
        counters_in[31:0] = 32'd7;
        sample_one("clr_b", 16'd1, 32'd7);
        counters_in[31:0] = 32'd3;
        sample_one("wrap", 16'd2, 32'd3);

        // 4: FIFO fill, drops, watermark, push+pop while full
        do_reset();
        src_mask = 8'hFF; watermark = 5'd12;
        for (int i = 0; i < 8; i++) counters_in[32*i +: 32] = 32'(10 * (i + 1));
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_idle();
        check("fill1_level", 32'(fifo_level), 32'd8);
        check("fill1_irq", {31'd0, irq_watermark}, 32'd0);
        check("fill1_head", rec_delta, 32'd10);
        repeat (10) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        step(); step(); step(); step();
        check("wm11_level", 32'(fifo_level), 32'd11);
        check("wm11_irq", {31'd0, irq_watermark}, 32'd0);
        step();
        check("wm12_level", 32'(fifo_level), 32'd12);
        check("wm12_irq", {31'd0, irq_watermark}, 32'd1);
        wait_idle();
        check("fill2_drop", 32'(drop_count), 32'd0);
        repeat (10) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_idle();
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_drop", 32'(drop_count), 32'd8);
        check("full_irq", {31'd0, irq_watermark}, 32'd1);
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        rec_ready = 1'b1;
        repeat (8) step();
        rec_ready = 1'b0;
        check("pp_level", 32'(fifo_level), 32'd16);
        check("pp_drop", 32'(drop_count), 32'd8);
        check("pp_busy", {31'd0, busy}, 32'd0);
        check("pp_head_ts", 32'(rec_ts), 32'd1);
        check("pp_head_src", 32'(rec_src), 32'd0);
        check("pp_head_delta", rec_delta, 32'd0);

        // 5: requests while busy are counted, not emitted
        do_reset();
        src_mask = 8'h01; rec_ready = 1'b1; counters_in[31:0] = 32'd42;
        p0 = pops;
        trigger = 1'b1; step(); step(); trigger = 1'b0;
        step(); step();
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_idle();
        step(); step();
        check("miss_records", 32'(pops - p0), 32'd1);
        check("miss_count", 32'(missed_samples), 32'd2);

        // 6: flush mid-EMIT with 5 records queued
        do_reset();
        src_mask = 8'h03; rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) counters_in[32*i +: 32] = 32'(i + 1);
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_idle();
        check("fl_pre_level", 32'(fifo_level), 32'd2);
        src_mask = 8'hFF;
        trigger = 1'b1; step(); trigger = 1'b0;
        step(); step(); step(); step();
        check("fl_queued", 32'(fifo_level), 32'd5);
        check("fl_busy_pre", {31'd0, busy}, 32'd1);
        flush = 1'b1; step(); flush = 1'b0;
        check("fl_level", 32'(fifo_level), 32'd0);
        check("fl_busy", {31'd0, busy}, 32'd0);
        check("fl_valid", {31'd0, rec_valid}, 32'd0);
        step();
        check("fl_stays_empty", 32'(fifo_level), 32'd0);
        src_mask = 8'h01; rec_ready = 1'b1;
        sample_one("fl_next", 16'd2, 32'd0);
        check("fl_drop", 32'(drop_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
